// File: rtl/instr_fetch_rv_if.sv
// Fetch-side bus: the instruction-memory req/ack port and the decode valid/ready port.
// The fetch unit is the master of both.
interface instr_fetch_rv_if;
    logic        orIMemReq;
    logic [31:0] orIMemAddr;
    logic        iwIMemAck;
    logic [31:0] iwIMemData;
    logic [31:0] orInstr;
    logic [31:0] orPc;
    logic        orValid;
    logic        iwReady;

    modport master (
        output orIMemReq, orIMemAddr, orInstr, orPc, orValid,
        input  iwIMemAck, iwIMemData, iwReady
    );

    modport slave (
        input  orIMemReq, orIMemAddr, orInstr, orPc, orValid,
        output iwIMemAck, iwIMemData, iwReady
    );
endinterface

// File: rtl/instr_fetch_rv.sv
// Instruction fetch and next-PC unit for the multi-cycle RV32I core: fetches one word,
// hands it to decode, waits for control resolution, then steps, jumps or halts.
module instr_fetch_rv #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             iwClk,
    input  logic             iwRst,
    instr_fetch_rv_if.master bus,
    input  logic             iwResolve,
    input  logic             iwnIllegal,
    input  logic [1:0]       iwNextPcSrc,
    input  logic [19:0]      iwNextPcImmediate20,
    input  logic [11:0]      iwNextPcImmediate12,
    input  logic [31:0]      iwJalrBase,
    input  logic             iwBranchCond,
    input  logic             iwBranchInverted,
    output logic [31:0]      orInstrCount,
    output logic             orHalted,
    output logic             orMisaligned
);
    localparam logic [1:0] NEXT_PC_SRC_SEQ  = 2'd0;
    localparam logic [1:0] NEXT_PC_SRC_JAL  = 2'd1;
    localparam logic [1:0] NEXT_PC_SRC_JALR = 2'd2;
    localparam logic [1:0] NEXT_PC_SRC_B    = 2'd3;

    typedef enum logic [1:0] {FETCH, PRESENT, WAIT_RESOLVE, HALT} fetchStateT;

    fetchStateT  state, stateNext;
    logic        req, reqNext;
    logic        valid, validNext;
    logic        halted, haltedNext;
    logic        misaligned, misalignedNext;
    logic [31:0] instr, instrNext;
    logic [31:0] pc, pcNext;
    logic [31:0] count, countNext;

    logic [31:0] jalOffset;
    logic [31:0] branchOffset;
    logic [31:0] jalrSum;
    logic [31:0] target;
    logic        branchTaken;

    // Immediates arrive as raw instruction fields and are unscrambled here.
    assign jalOffset = {{11{iwNextPcImmediate20[19]}}, iwNextPcImmediate20[19],
                        iwNextPcImmediate20[7:0], iwNextPcImmediate20[8],
                        iwNextPcImmediate20[18:9], 1'b0};
    assign branchOffset = {{19{iwNextPcImmediate12[11]}}, iwNextPcImmediate12[11],
                           iwNextPcImmediate12[0], iwNextPcImmediate12[10:5],
                           iwNextPcImmediate12[4:1], 1'b0};
    assign jalrSum     = iwJalrBase + {{20{iwNextPcImmediate12[11]}}, iwNextPcImmediate12};
    assign branchTaken = iwBranchCond ^ iwBranchInverted;

    always_comb begin
        unique case (iwNextPcSrc)
            NEXT_PC_SRC_SEQ:  target = pc + 32'd4;
            NEXT_PC_SRC_JAL:  target = pc + jalOffset;
            NEXT_PC_SRC_JALR: target = {jalrSum[31:1], 1'b0};
            NEXT_PC_SRC_B:    target = branchTaken ? (pc + branchOffset) : (pc + 32'd4);
            default:          target = pc + 32'd4;
        endcase
    end

    always_comb begin
        // NOTE: every next value defaults to its current value first, so no branch of the case infers a latch.
        stateNext      = state;
        reqNext        = req;
        validNext      = valid;
        instrNext      = instr;
        pcNext         = pc;
        countNext      = count;
        haltedNext     = halted;
        misalignedNext = misaligned;

        unique case (state)
            FETCH: begin
                if (req && bus.iwIMemAck) begin
                    instrNext = bus.iwIMemData;
                    validNext = 1'b1;
                    reqNext   = 1'b0;
                    stateNext = PRESENT;
                end else begin
                    reqNext = 1'b1;
                end
            end
            PRESENT: begin
                if (bus.iwReady) begin
                    validNext = 1'b0;
                    stateNext = WAIT_RESOLVE;
                end
            end
            WAIT_RESOLVE: begin
                if (iwResolve) begin
                    if (!iwnIllegal) begin
                        haltedNext = 1'b1;
                        stateNext  = HALT;
                    end else if (target[1:0] != 2'b00) begin
                        haltedNext     = 1'b1;
                        misalignedNext = 1'b1;
                        stateNext      = HALT;
                    end else begin
                        pcNext    = target;
                        countNext = count + 32'd1;
                        stateNext = FETCH;
                    end
                end
            end
            HALT: begin
                // Terminal until reset; everything stays frozen.
            end
            default: stateNext = HALT;
        endcase
    end

    always_ff @(posedge iwClk) begin
        // NOTE: sequential state is written with non-blocking assignments so all registers update together.
        if (iwRst) begin
            state      <= FETCH;
            req        <= 1'b0;
            valid      <= 1'b0;
            instr      <= 32'd0;
            pc         <= RESET_PC;
            count      <= 32'd0;
            halted     <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            state      <= stateNext;
            req        <= reqNext;
            valid      <= validNext;
            instr      <= instrNext;
            pc         <= pcNext;
            count      <= countNext;
            halted     <= haltedNext;
            misaligned <= misalignedNext;
        end
    end

    assign bus.orIMemReq  = req;
    assign bus.orIMemAddr = pc;
    assign bus.orInstr    = instr;
    assign bus.orPc       = pc;
    assign bus.orValid    = valid;
    assign orInstrCount   = count;
    assign orHalted       = halted;
    assign orMisaligned   = misaligned;
endmodule

// File: tb/tb_instr_fetch_rv.sv
// Randomized bench for instr_fetch_rv: the bench plays memory, decoder and execute stage;
// a scoreboard monitor checks every instruction handed to decode.
module tb_instr_fetch_rv;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [1:0]  SRC_SEQ  = 2'd0;
    localparam logic [1:0]  SRC_JAL  = 2'd1;
    localparam logic [1:0]  SRC_JALR = 2'd2;
    localparam logic [1:0]  SRC_B    = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        iwResolve;
    logic        iwnIllegal;
    logic [1:0]  iwNextPcSrc;
    logic [19:0] iwNextPcImmediate20;
    logic [11:0] iwNextPcImmediate12;
    logic [31:0] iwJalrBase;
    logic        iwBranchCond;
    logic        iwBranchInverted;
    logic [31:0] orInstrCount;
    logic        orHalted;
    logic        orMisaligned;

    instr_fetch_rv_if bus();

    instr_fetch_rv #(.RESET_PC(RESET_PC)) dut (
        .iwClk               (clk),
        .iwRst               (rst),
        .bus                 (bus.master),
        .iwResolve           (iwResolve),
        .iwnIllegal          (iwnIllegal),
        .iwNextPcSrc         (iwNextPcSrc),
        .iwNextPcImmediate20 (iwNextPcImmediate20),
        .iwNextPcImmediate12 (iwNextPcImmediate12),
        .iwJalrBase          (iwJalrBase),
        .iwBranchCond        (iwBranchCond),
        .iwBranchInverted    (iwBranchInverted),
        .orInstrCount        (orInstrCount),
        .orHalted            (orHalted),
        .orMisaligned        (orMisaligned)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] count;
    } presentT;

    presentT     expQ[$];
    logic [31:0] modelPc;
    logic [31:0] modelCount;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic finishRun();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    endtask

    // Next PC straight from the RISC-V immediate definitions, rebuilt from instruction bits.
    function automatic logic [31:0] modelTarget(input logic [31:0] pc, input logic [1:0] src,
                                                input logic [19:0] i20, input logic [11:0] i12,
                                                input logic [31:0] base, input logic cond,
                                                input logic inv);
        logic [31:0] word;
        logic [31:0] r;
        longint      imm;
        longint      t;
        imm = 4;
        t   = pc;
        case (src)
            SRC_JAL: begin
                word = {i20, 12'h000};
                imm  = 2 * word[30:21] + 2048 * word[20] + 4096 * word[19:12];
                if (word[31]) imm = imm - (64'sd1 <<< 20);
            end
            SRC_B: begin
                word = {i12[11:5], 13'h0000, i12[4:0], 7'h00};
                if (cond != inv) begin
                    imm = 2 * word[11:8] + 32 * word[30:25] + 2048 * word[7];
                    if (word[31]) imm = imm - 4096;
                end
            end
            SRC_JALR: begin
                imm = i12;
                if (i12[11]) imm = imm - 4096;
                t = base;
            end
            default: imm = 4;
        endcase
        t = t + imm;
        r = t[31:0];
        if (src == SRC_JALR) r = r - (r % 2);
        return r;
    endfunction

    // Scoreboard monitor: every new decode presentation must match the oldest queued fetch.
    logic    prevValid = 1'b0;
    presentT lastE;
    always @(negedge clk) begin
        if (!rst && bus.orValid && !prevValid) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("FAIL unexpected_present: pc %h instr %h, nothing queued", bus.orPc, bus.orInstr);
            end else begin
                lastE = expQ.pop_front();
                check("present_instr", bus.orInstr, lastE.instr);
                check("present_pc", bus.orPc, lastE.pc);
                check("present_count", orInstrCount, lastE.count);
            end
        end else if (!rst && bus.orValid && prevValid) begin
            check("hold_instr", bus.orInstr, lastE.instr);
            check("hold_pc", bus.orPc, lastE.pc);
        end
        prevValid = rst ? 1'b0 : bus.orValid;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic randControls();
        iwnIllegal          = $urandom_range(0, 1) == 1;
        iwNextPcSrc         = 2'($urandom_range(0, 3));
        iwNextPcImmediate20 = 20'($urandom);
        iwNextPcImmediate12 = 12'($urandom);
        iwJalrBase          = $urandom;
        iwBranchCond        = $urandom_range(0, 1) == 1;
        iwBranchInverted    = $urandom_range(0, 1) == 1;
    endtask

    // Noise on inputs that the current state must ignore.
    task automatic junk(input bit ackOk, input bit resolveOk, input bit readyOk);
        bus.iwIMemAck  = ackOk ? ($urandom_range(0, 1) == 1) : 1'b0;
        bus.iwIMemData = $urandom;
        iwResolve      = resolveOk ? ($urandom_range(0, 1) == 1) : 1'b0;
        bus.iwReady    = readyOk ? ($urandom_range(0, 1) == 1) : 1'b0;
        randControls();
    endtask

    task automatic doReset();
        rst = 1'b1;
        junk(1, 1, 1);
        tick();
        junk(1, 1, 1);
        tick();
        check("rst_req", bus.orIMemReq, 0);
        check("rst_valid", bus.orValid, 0);
        check("rst_instr", bus.orInstr, 0);
        check("rst_pc", bus.orPc, RESET_PC);
        check("rst_addr", bus.orIMemAddr, RESET_PC);
        check("rst_count", orInstrCount, 0);
        check("rst_halted", orHalted, 0);
        check("rst_misaligned", orMisaligned, 0);
        rst = 1'b0;
        junk(0, 1, 1);
        bus.iwIMemAck = 1'b1;
        tick();
        check("post_rst_req", bus.orIMemReq, 1);
        check("post_rst_stray_ack", bus.orValid, 0);
        bus.iwIMemAck = 1'b0;
        modelPc    = RESET_PC;
        modelCount = 0;
        expQ.delete();
    endtask

    task automatic run(input logic [31:0] data, input logic nIll, input logic [1:0] src,
                       input logic [19:0] i20, input logic [11:0] i12, input logic [31:0] base,
                       input logic cond, input logic inv, input int ackDelay,
                       input bit resetInWait, output bit halted);
        int          waited;
        int          readyDelay;
        int          resolveDelay;
        logic [31:0] tgt;
        presentT     e;
        halted = 1'b0;
        waited = 0;
        while (!bus.orIMemReq) begin
            junk(0, 0, 1);
            tick();
            waited++;
            if (waited > 10) begin
                testsRun++;
                testsFailed++;
                $display("FAIL req_timeout: no fetch request within 10 cycles at pc %h", modelPc);
                finishRun();
            end
        end
        check("fetch_addr", bus.orIMemAddr, modelPc);
        if (ackDelay < 0) ackDelay = $urandom_range(0, 3);
        repeat (ackDelay) begin
            junk(0, 1, 1);
            tick();
            check("req_held", bus.orIMemReq, 1);
        end
        junk(0, 1, 1);
        bus.iwIMemAck  = 1'b1;
        bus.iwIMemData = data;
        e.instr = data;
        e.pc    = modelPc;
        e.count = modelCount;
        expQ.push_back(e);
        tick();
        check("ack_to_valid", bus.orValid, 1);
        check("req_dropped", bus.orIMemReq, 0);
        readyDelay = $urandom_range(0, 2);
        repeat (readyDelay) begin
            junk(1, 1, 0);
            tick();
        end
        junk(1, 1, 0);
        bus.iwReady = 1'b1;
        tick();
        check("valid_cleared", bus.orValid, 0);
        if (resetInWait) begin
            junk(1, 0, 1);
            tick();
            doReset();
            return;
        end
        resolveDelay = $urandom_range(0, 2);
        repeat (resolveDelay) begin
            junk(1, 0, 1);
            tick();
        end
        junk(1, 0, 1);
        iwResolve           = 1'b1;
        iwnIllegal          = nIll;
        iwNextPcSrc         = src;
        iwNextPcImmediate20 = i20;
        iwNextPcImmediate12 = i12;
        iwJalrBase          = base;
        iwBranchCond        = cond;
        iwBranchInverted    = inv;
        tgt = modelTarget(modelPc, src, i20, i12, base, cond, inv);
        tick();
        iwResolve = 1'b0;
        if (!nIll || tgt[1:0] != 2'b00) begin
            halted = 1'b1;
            check("halt_flag", orHalted, 1);
            check("halt_misaligned", orMisaligned, nIll ? 1 : 0);
            repeat (4) begin
                junk(1, 1, 1);
                tick();
                check("halt_no_req", bus.orIMemReq, 0);
            end
            check("halt_pc", bus.orPc, modelPc);
            check("halt_count", orInstrCount, modelCount);
            check("halt_valid", bus.orValid, 0);
            check("halt_hold", orHalted, 1);
        end else begin
            modelPc    = tgt;
            modelCount = modelCount + 1;
            check("next_pc", bus.orPc, modelPc);
            check("count", orInstrCount, modelCount);
            check("req_low_after_resolve", bus.orIMemReq, 0);
            junk(1, 1, 1);
            tick();
            check("req_reasserted", bus.orIMemReq, 1);
            bus.iwIMemAck = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          h;
        logic [19:0] i20;
        logic [11:0] i12;
        logic [31:0] base;
        rst = 1'b1;
        bus.iwIMemAck  = 1'b0;
        bus.iwIMemData = 32'd0;
        bus.iwReady    = 1'b0;
        iwResolve      = 1'b0;
        randControls();
        tick();
        doReset();

        run(32'h00500093, 1, SRC_SEQ,  0, 0, 0, 0, 0, 2, 0, h);
        run($urandom, 1, SRC_JALR, 0, 12'h000, 32'h10, 0, 0, -1, 0, h);
        run($urandom, 1, SRC_SEQ,  0, 0, 0, 0, 0, -1, 0, h);
        run($urandom, 1, SRC_JALR, 0, 12'h000, 32'h100, 0, 0, -1, 0, h);
        run($urandom, 1, SRC_JAL,  20'h00800, 0, 0, 0, 0, -1, 0, h);
        run($urandom, 1, SRC_JALR, 0, 12'h000, 32'h100, 0, 0, -1, 0, h);
        run($urandom, 1, SRC_JAL,  20'hFFDFF, 0, 0, 0, 0, -1, 0, h);
        run($urandom, 1, SRC_JALR, 0, 12'h000, 32'h40, 0, 0, -1, 0, h);
        run($urandom, 1, SRC_B,    0, 12'h010, 0, 0, 1, -1, 0, h);
        run($urandom, 1, SRC_JALR, 0, 12'h000, 32'h40, 0, 0, -1, 0, h);
        run($urandom, 1, SRC_B,    0, 12'h010, 0, 1, 1, -1, 0, h);
        run($urandom, 1, SRC_JALR, 0, 12'hFFF, 32'h205, 0, 0, -1, 0, h);
        run($urandom, 1, SRC_JALR, 0, 12'h000, 32'hFFFF_FFFC, 0, 0, -1, 0, h);
        run($urandom, 1, SRC_SEQ,  0, 0, 0, 0, 0, -1, 0, h);
        run($urandom, 1, SRC_JALR, 0, 12'h002, 32'h200, 0, 0, -1, 0, h);
        doReset();
        run($urandom, 1, SRC_JALR, 0, 12'hFFF, 32'h203, 0, 0, -1, 0, h);
        doReset();
        run($urandom, 1, SRC_SEQ,  0, 0, 0, 0, 0, -1, 0, h);
        run($urandom, 0, SRC_SEQ,  0, 0, 0, 0, 0, -1, 0, h);
        doReset();
        run($urandom, 1, SRC_SEQ,  0, 0, 0, 0, 0, -1, 0, h);
        run($urandom, 1, SRC_SEQ,  0, 0, 0, 0, 0, -1, 1, h);

        for (int n = 0; n < 150; n++) begin
            i20  = 20'($urandom);
            i12  = 12'($urandom);
            base = $urandom;
            if ($urandom_range(0, 3) != 0) i20[9] = 1'b0;
            if ($urandom_range(0, 3) != 0) begin
                i12[2]    = 1'b0;
                i12[1]    = 1'b0;
                base[1:0] = 2'b00;
            end
            run($urandom, $urandom_range(0, 15) != 0, 2'($urandom_range(0, 3)), i20, i12, base,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, -1,
                $urandom_range(0, 19) == 0, h);
            if (h) doReset();
        end

        check("scoreboard_drained", expQ.size(), 0);
        finishRun();
    end
endmodule
